// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues req/ack word fetches and buffers
// returned words in a prefetch FIFO for decode. Optional FETCH_BYPASS_EN forwards ack data straight to decode.
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        out_valid,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   input  logic        out_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

   state_t             state;
   logic [31:0]        fetch_pc;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic [31:0]        fifo_instr_p1 [DEPTH];
   logic [31:0]        fifo_pc_p1    [DEPTH];

   logic               ack_v;
   logic               fifo_empty;
   logic               bypass;
   logic               push;
   logic               pop;
   logic [CNT_W-1:0]   count_nxt;
   logic               slot_free_nxt;
   logic [31:0]        redirect_pc_al;
   logic [31:0]        fetch_pc_inc;

   always_comb begin
      ack_v          = imem_req & imem_ack;
      fifo_empty     = (count == '0);
      redirect_pc_al = redirect_pc & ~32'h3;
      fetch_pc_inc   = fetch_pc + 32'd4;
      bypass         = 1'b0;
      out_valid      = ~fifo_empty;
      out_instr      = fifo_empty ? '0 : fifo_instr_p1[rd_ptr];
      out_pc         = fifo_empty ? '0 : fifo_pc_p1[rd_ptr];
`ifdef FETCH_BYPASS_EN
      // Empty queue: the returning word goes to decode in the ack cycle.
      bypass = (state == S_WAIT) & ack_v & fifo_empty & ~redirect;
      if (bypass) begin
         out_valid = 1'b1;
         out_instr = imem_rdata;
         out_pc    = fetch_pc;
      end
`endif
      pop           = ~fifo_empty & out_ready & ~redirect;
      push          = (state == S_WAIT) & ack_v & ~redirect & ~(bypass & out_ready);
      count_nxt     = count + CNT_W'(push) - CNT_W'(pop);
      slot_free_nxt = (count_nxt < CNT_W'(DEPTH));
   end

   // Control stage: fetch state, request port and queue bookkeeping
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         imem_req  <= 1'b0;
         imem_addr <= RESET_PC;
         fetch_pc  <= RESET_PC;
         count     <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
      end else if (redirect) begin
         fetch_pc <= redirect_pc_al;
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         // A request still in flight must be absorbed before the new target is issued.
         if (imem_req && !imem_ack) begin
            state <= S_DROP;
         end else begin
            state     <= S_WAIT;
            imem_req  <= 1'b1;
            imem_addr <= redirect_pc_al;
         end
      end else begin
         count <= count_nxt;
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case (state)
            S_IDLE: begin
               if (count < CNT_W'(DEPTH)) begin
                  state     <= S_WAIT;
                  imem_req  <= 1'b1;
                  imem_addr <= fetch_pc;
               end
            end
            S_WAIT: begin
               if (ack_v) begin
                  fetch_pc <= fetch_pc_inc;
                  if (slot_free_nxt) begin
                     imem_addr <= fetch_pc_inc;
                  end else begin
                     state    <= S_IDLE;
                     imem_req <= 1'b0;
                  end
               end
            end
            S_DROP: begin
               if (ack_v) begin
                  state     <= S_WAIT;
                  imem_addr <= fetch_pc;
               end
            end
            default: begin
               state    <= S_IDLE;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

   // Data stage: queue storage, written one cycle after ack
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_instr_p1[wr_ptr] <= imem_rdata;
         fifo_pc_p1[wr_ptr]    <= fetch_pc;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus randomized traffic against a word-stream model.
module tb_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_ready;
   logic        redirect;
   logic [31:0] redirect_pc;

   int checks = 0;
   int errors = 0;

   // memory responder and stream model state
   int          lat;
   int          wcnt;
   bit          rand_lat;
   int          acks;
   logic [31:0] exp_pc;
   logic        prev_req;
   logic        prev_ack;
   logic        prev_redir;
   logic [31:0] prev_addr;
   logic [31:0] popped[$];

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
      .out_ready(out_ready), .redirect(redirect), .redirect_pc(redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_1234;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic respond();
      if (!imem_req) begin
         imem_ack   = 1'b0;
         imem_rdata = $urandom;
         wcnt       = 0;
      end else if (wcnt >= lat) begin
         imem_ack   = 1'b1;
         imem_rdata = memf(imem_addr);
         wcnt       = 0;
         if (rand_lat) lat = $urandom_range(0, 3);
      end else begin
         imem_ack   = 1'b0;
         imem_rdata = $urandom;
         wcnt++;
      end
   endtask

   // Decode must see a gap-free word stream starting at each restart address.
   task automatic monitor();
      if (imem_req) chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
      if (prev_req && !prev_ack) begin
         chk("req_held", 32'(imem_req), 32'd1);
         chk("addr_held", imem_addr, prev_addr);
      end
      if (prev_redir && !(BYP && imem_ack)) chk("flush_valid", 32'(out_valid), 32'd0);
      if (redirect) begin
         exp_pc = redirect_pc & ~32'h3;
      end else if (out_valid && out_ready) begin
         chk("stream_pc", out_pc, exp_pc);
         chk("stream_instr", out_instr, memf(exp_pc));
         popped.push_back(out_pc);
         exp_pc = exp_pc + 32'd4;
      end
      if (imem_req && imem_ack) acks++;
      prev_req   = imem_req;
      prev_ack   = imem_ack;
      prev_addr  = imem_addr;
      prev_redir = redirect;
   endtask

   task automatic cyc(input logic rdy, input logic rd, input logic [31:0] rpc);
      @(negedge clk);
      out_ready   = rdy;
      redirect    = rd;
      redirect_pc = rpc;
      respond();
      #1;
      monitor();
   endtask

   task automatic do_reset(input bit stray);
      @(negedge clk);
      reset     = 1'b1;
      imem_ack  = 1'b0;
      out_ready = 1'b0;
      redirect  = 1'b0;
      #1;
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_addr", imem_addr, RESET_PC);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_instr", out_instr, 32'd0);
      chk("rst_pc", out_pc, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      if (stray) begin
         imem_ack   = 1'b1;
         imem_rdata = 32'hDEAD_BEEF;
      end
      exp_pc     = RESET_PC;
      prev_req   = 1'b0;
      prev_ack   = 1'b0;
      prev_redir = 1'b0;
      wcnt       = 0;
      acks       = 0;
      rand_lat   = 1'b0;
      popped.delete();
   endtask

   initial begin
      logic [31:0] first;
      logic [31:0] tgt;
      bit          seen;
      bit          saw8;
      logic        rdy;
      logic        rd;

      reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
      out_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
      lat = 0; wcnt = 0; rand_lat = 1'b0; acks = 0; exp_pc = RESET_PC;
      prev_req = 1'b0; prev_ack = 1'b0; prev_redir = 1'b0; prev_addr = '0;

      // zero-wait memory, decode always ready
      lat = 0;
      do_reset(1'b0);
      cyc(1'b1, 1'b0, '0);
      chk("t1_req", 32'(imem_req), 32'd1);
      chk("t1_addr0", imem_addr, 32'd0);
      chk("t1_valid0", 32'(out_valid), 32'(BYP));
      for (int i = 1; i <= 6; i++) begin
         cyc(1'b1, 1'b0, '0);
         chk("t1_addr", imem_addr, 32'(4 * i));
         chk("t1_valid", 32'(out_valid), 32'd1);
         chk("t1_pc", out_pc, 32'(4 * (i - 1 + int'(BYP))));
         chk("t1_instr", out_instr, memf(32'(4 * (i - 1 + int'(BYP)))));
      end

      // decode stalled: queue fills to DEPTH and fetch stops
      do_reset(1'b0);
      for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, '0);
      chk("t2_acks", 32'(acks), 32'(DEPTH));
      chk("t2_req_off", 32'(imem_req), 32'd0);
      chk("t2_valid", 32'(out_valid), 32'd1);
      chk("t2_head", out_pc, 32'd0);
      popped.delete();
      seen  = 1'b0;
      first = 32'hFFFF_FFFF;
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 1'b0, '0);
         if (imem_req && !seen) begin
            seen  = 1'b1;
            first = imem_addr;
         end
      end
      chk("t2_resume", first, 32'd16);
      chk("t2_npop", 32'(popped.size() >= 4), 32'd1);
      for (int k = 0; k < 4 && k < popped.size(); k++) chk("t2_drain", popped[k], 32'(4 * k));

      // slow memory, redirect while the fetch of 8 is pending
      do_reset(1'b0);
      lat  = 3;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         cyc(1'b1, 1'b0, '0);
         if (imem_req && imem_addr == 32'd8) seen = 1'b1;
      end
      chk("t3_reach8", 32'(seen), 32'd1);
      popped.delete();
      cyc(1'b1, 1'b1, 32'h100);
      chk("t3_pending", 32'(imem_req), 32'd1);
      first = 32'hFFFF_FFFF;
      saw8  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cyc(1'b1, 1'b0, '0);
         if (imem_req && imem_addr != 32'd8 && first == 32'hFFFF_FFFF) first = imem_addr;
         if (out_valid && out_pc == 32'd8) saw8 = 1'b1;
      end
      chk("t3_next_req", first, 32'h100);
      chk("t3_no_pc8", 32'(saw8), 32'd0);
      first = 32'hFFFF_FFFF;
      if (popped.size() > 0) first = popped[0];
      chk("t3_first_out", first, 32'h100);

      // redirect together with ack and pop, two entries queued
      do_reset(1'b0);
      lat = 0;
      cyc(1'b0, 1'b0, '0);
      cyc(1'b0, 1'b0, '0);
      chk("t4_queued", 32'(out_valid), 32'd1);
      popped.delete();
      cyc(1'b1, 1'b1, 32'h200);
      lat = 1;
      cyc(1'b1, 1'b0, '0);
      chk("t4_flush", 32'(out_valid), 32'd0);
      chk("t4_req", 32'(imem_req), 32'd1);
      chk("t4_addr", imem_addr, 32'h200);
      chk("t4_nopop", 32'(popped.size()), 32'd0);
      for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, '0);
      first = 32'hFFFF_FFFF;
      if (popped.size() > 0) first = popped[0];
      chk("t4_restart", first, 32'h200);

      // reset in the middle of a request, then a stray ack
      do_reset(1'b0);
      lat = 3;
      cyc(1'b1, 1'b0, '0);
      cyc(1'b1, 1'b0, '0);
      chk("t5_inwait", 32'(imem_req), 32'd1);
      lat = 1;
      do_reset(1'b1);
      lat = 1;
      cyc(1'b1, 1'b0, '0);
      chk("t5_req", 32'(imem_req), 32'd1);
      chk("t5_addr", imem_addr, RESET_PC);
      chk("t5_valid", 32'(out_valid), 32'd0);
      lat = 0;
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, '0);
      first = 32'hFFFF_FFFF;
      if (popped.size() > 0) first = popped[0];
      chk("t5_restart", first, RESET_PC);

      // ack-to-decode latency
      do_reset(1'b0);
      lat = 0;
      cyc(1'b0, 1'b0, '0);
      chk("t6_same_valid", 32'(out_valid), 32'(BYP));
      cyc(1'b0, 1'b0, '0);
      chk("t6_next_valid", 32'(out_valid), 32'd1);
      chk("t6_instr", out_instr, memf(32'd0));
      chk("t6_pc", out_pc, 32'd0);

      // randomized traffic
      do_reset(1'b0);
      rand_lat = 1'b1;
      lat      = $urandom_range(0, 3);
      for (int i = 0; i < 3000; i++) begin
         rdy = ((i % 400) < 100) ? 1'b0 : ($urandom_range(0, 9) < 7);
         rd  = ($urandom_range(0, 49) == 0);
         case ($urandom_range(0, 3))
            0:       tgt = $urandom;
            1:       tgt = 32'hFFFF_FFF4 | 32'($urandom_range(0, 3));
            2:       tgt = 32'h0000_1000 + 32'($urandom_range(0, 63));
            default: tgt = 32'($urandom_range(0, 255)) << 2;
         endcase
         cyc(rdy, rd, tgt);
      end
      chk("rnd_progress", 32'(popped.size() > 300), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
